adder_n_serial: RTL

ADDER_N_SERIAL -- requirements
Module: adder_n_serial

---
 rtl/adder_n_serial.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/adder_n_serial.sv
// ---------------------------------------------------------------------------
// adder_n_serial
//
// Bit-serial ripple adder. On an accepted start the operands are captured and
// one bit is added per clock, LSB first, through a single full adder whose
// carry is kept in a register. The result is presented WIDTH cycles later
// together with a one-cycle done pulse, and held until the next accepted start.
//
// Optional feature macro: ADDER_N_SERIAL_SUB_EN
//   When defined, adds input 'sub' (subtract a-b as a+~b+1, cin ignored) and
//   output 'ovf' (signed two's-complement overflow of the last operation).
//
// Parameters
//   WIDTH  operand/result width in bits (1..32)
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   start  request a new operation (accepted in IDLE or DONE only)
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (macro only) subtract select, captured on an accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse when sum/cout (and ovf) are final
//   sum    a+b+cin modulo 2^WIDTH
//   cout   carry out of bit WIDTH-1
//   ovf    (macro only) signed overflow of the last result
// ---------------------------------------------------------------------------
module adder_n_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_N_SERIAL_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             carry_reg, carry_next;
   logic             cout_reg, cout_next;
   logic             sub_op;
   logic             bit_sum;
   logic             bit_carry;

`ifdef ADDER_N_SERIAL_SUB_EN
   logic             ovf_reg, ovf_next;
   assign sub_op = sub;
`else
   assign sub_op = 1'b0;
`endif

   // Operands are shift registers; bit 0 is always the bit being added.
   assign bit_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
   assign bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

   // -----------------------------------------------------------------------
   // State register and datapath registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
`ifdef ADDER_N_SERIAL_SUB_EN
         ovf_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sum_reg   <= sum_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
`ifdef ADDER_N_SERIAL_SUB_EN
         ovf_reg   <= ovf_next;
`endif
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and datapath logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sum_next   = sum_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
`ifdef ADDER_N_SERIAL_SUB_EN
      ovf_next   = ovf_reg;
`endif
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = RUN;
               a_next     = a;
               // Subtraction is a + ~b + 1: invert b once at capture and
               // seed the carry with 1 instead of cin.
               b_next     = sub_op ? ~b : b;
               carry_next = sub_op ? 1'b1 : cin;
               cnt_next   = '0;
               sum_next   = '0;
               cout_next  = 1'b0;
`ifdef ADDER_N_SERIAL_SUB_EN
               ovf_next   = 1'b0;
`endif
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            a_next     = a_reg >> 1;
            b_next     = b_reg >> 1;
            carry_next = bit_carry;
            // New bits enter at the MSB; after WIDTH shifts bit 0 of the
            // result has reached position 0.
            sum_next   = (sum_reg >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
            if (cnt_reg == LAST_BIT) begin
               state_next = DONE;
               cout_next  = bit_carry;
`ifdef ADDER_N_SERIAL_SUB_EN
               // Overflow: carry into the sign bit differs from carry out.
               ovf_next   = bit_carry ^ carry_reg;
`endif
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;
`ifdef ADDER_N_SERIAL_SUB_EN
   assign ovf  = ovf_reg;
`endif

endmodule
